// File: rtl/ff_response_checker_if.sv
// ff_response_checker_if
//   Groups the tester's handshake, result and flip-flop-under-test signals.
//   master: the checker (drives the FF pins and results, reads start/Q/NQ).
//   slave : the surrounding board / bench (drives start and Q/NQ).
// Signals:
//   start              one-cycle run request
//   q_in, nq_in        Q / NQ returned by the flip-flop under test
//   d_out, s_n_out,
//   r_n_out, tclk_out  stimulus to the flip-flop under test
//   busy, done, pass   run status
//   err_cnt            saturating count of mismatching vectors
//   fail_idx           index of the first mismatching vector
interface ff_response_checker_if #(
    parameter int ERR_W = 8,
    parameter int IDX_W = 8
);
    logic             start;
    logic             q_in;
    logic             nq_in;
    logic             d_out;
    logic             s_n_out;
    logic             r_n_out;
    logic             tclk_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [IDX_W-1:0] fail_idx;

    modport master (
        input  start, q_in, nq_in,
        output d_out, s_n_out, r_n_out, tclk_out, busy, done, pass, err_cnt, fail_idx
    );

    modport slave (
        output start, q_in, nq_in,
        input  d_out, s_n_out, r_n_out, tclk_out, busy, done, pass, err_cnt, fail_idx
    );
endinterface

// File: rtl/ff_response_checker.sv
// ff_response_checker
//   On-board tester for an external edge-triggered D flip-flop with active-low
//   async set/reset. Each run drives VECTORS vectors; every vector spends HALF
//   CP cycles with the test clock low and HALF cycles high. Q/NQ are sampled on
//   the last high cycle and compared with a golden model.
// Ports:
//   CP   system clock (rising edge)
//   RST  asynchronous active-high reset
//   bus  ff_response_checker_if.master (start, q_in/nq_in in; FF stimulus,
//        busy/done/pass/err_cnt/fail_idx out)
// Parameters: VECTORS (2..256), HALF (1..15), ERR_W, IDX_W (2^IDX_W >= VECTORS)
// Optional feature: define FF_CHECK_HALT_EN to stop the run at the first
//   mismatching vector instead of running all vectors.
module ff_response_checker #(
    parameter int VECTORS = 16,
    parameter int HALF    = 2,
    parameter int ERR_W   = 8,
    parameter int IDX_W   = 8
) (
    input  logic                  CP,
    input  logic                  RST,
    ff_response_checker_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             exp_q;
    logic [3:0]       phase;

    logic             last_phase;
    logic             mismatch;
    logic             halt;
    logic             last_vec;
    logic [ERR_W-1:0] err_next;
    logic [IDX_W-1:0] idx_inc;

    // Vector stimulus from the low nibble of the index: {d, s_n, r_n}.
    // Set and reset are asserted on disjoint nibbles, so never both low.
    function automatic logic [2:0] vec_of(input logic [3:0] i4);
        logic d, s_n, r_n;
        d   = i4[0] ^ i4[2];
        r_n = !(i4 == 4'd0 || i4 == 4'd10);
        s_n = !(i4 == 4'd5);
        return {d, s_n, r_n};
    endfunction

    assign last_phase = (phase == 4'(HALF - 1));
    assign mismatch   = (bus.q_in != exp_q) || (bus.nq_in != ~exp_q);
    assign last_vec   = (idx == IDX_W'(VECTORS - 1));
    assign idx_inc    = idx + 1'b1;
    // Saturating increment on a mismatch.
    assign err_next   = (mismatch && bus.err_cnt != '1) ? bus.err_cnt + 1'b1 : bus.err_cnt;

`ifdef FF_CHECK_HALT_EN
    assign halt = mismatch;
`else
    assign halt = 1'b0;
`endif

    always_ff @(posedge CP or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            idx          <= '0;
            exp_q        <= 1'b0;
            phase        <= '0;
            bus.d_out    <= 1'b0;
            bus.s_n_out  <= 1'b1;
            bus.r_n_out  <= 1'b1;
            bus.tclk_out <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.pass     <= 1'b0;
            bus.err_cnt  <= '0;
            bus.fail_idx <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state        <= LOW;
                        idx          <= '0;
                        phase        <= '0;
                        bus.err_cnt  <= '0;
                        bus.fail_idx <= '0;
                        bus.busy     <= 1'b1;
                        bus.done     <= 1'b0;
                        bus.pass     <= 1'b0;
                        bus.tclk_out <= 1'b0;
                        {bus.d_out, bus.s_n_out, bus.r_n_out} <= vec_of(4'd0);
                    end
                end
                LOW: begin
                    if (last_phase) begin
                        state        <= HIGH;
                        phase        <= '0;
                        bus.tclk_out <= 1'b1;
                        // Golden response: async reset wins, then set, then D.
                        exp_q <= !bus.r_n_out ? 1'b0 : (!bus.s_n_out ? 1'b1 : bus.d_out);
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                HIGH: begin
                    if (last_phase) begin
                        phase        <= '0;
                        bus.tclk_out <= 1'b0;
                        bus.err_cnt  <= err_next;
                        // err_cnt never returns to zero once bumped, so zero
                        // here marks the first failing vector.
                        if (mismatch && bus.err_cnt == '0)
                            bus.fail_idx <= idx;
                        if (last_vec || halt) begin
                            state       <= DONE;
                            bus.busy    <= 1'b0;
                            bus.done    <= 1'b1;
                            bus.pass    <= (err_next == '0);
                            bus.s_n_out <= 1'b1;
                            bus.r_n_out <= 1'b1;
                        end else begin
                            state <= LOW;
                            idx   <= idx_inc;
                            {bus.d_out, bus.s_n_out, bus.r_n_out} <= vec_of(4'(idx_inc));
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
